// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter that shares one single-ported RAM
// among NUM_CH requesting channels.
//
// Ports
//   CLK, nRST              clock (rising edge), synchronous active-low reset
//   req_REN / req_WEN      per-channel read / write requests
//   req_addr / req_store   packed per-channel address / write data
//   req_wait               per-channel stall (drops on completion/error)
//   req_load               read data broadcast to all channels
//   req_err                per-channel one-cycle error pulse
//   ramREN/ramWEN/ramaddr/ramstore  RAM command side
//   ramload / ramstate     RAM read data and status
//
// Optional feature macro: RAM_ARB_TIMEOUT_EN adds a BUSY watchdog that
// errors out an access after TIMEOUT_CYC stalled cycles.

package ram_arb_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// state  | meaning
// S_IDLE | no access in flight; pick next channel, RAM outputs held at 0
// S_BUSY | granted channel drives the RAM until ACCESS/ERROR/abort/timeout
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NUM_CH-1:0]        req_REN,
  input  logic [NUM_CH-1:0]        req_WEN,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_store,
  output logic [NUM_CH-1:0]        req_wait,
  output logic [DATA_W-1:0]        req_load,
  output logic [NUM_CH-1:0]        req_err,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  input  logic [DATA_W-1:0]        ramload,
  input  ramstate_t                ramstate
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("ram_port_arbiter: NUM_CH must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic [GW-1:0]     r_grant, w_grant_nxt;
  logic [GW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [GW-1:0]     w_pick, w_grant_inc;
  logic [NUM_CH-1:0] w_req, w_grant_oh;
  logic              w_any;
  logic              w_g_ren, w_g_wen;
  logic [ADDR_W-1:0] w_g_addr;
  logic [DATA_W-1:0] w_g_store;
  logic              w_timeout;

  assign w_req       = req_REN | req_WEN;
  assign w_any       = |w_req;
  assign w_grant_oh  = NUM_CH'(1) << r_grant;
  assign w_grant_inc = (r_grant == GW'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

  // Two descending passes: the first finds the lowest requester overall
  // (the wrap-around case), the second overrides it with the lowest
  // requester at or after rr_ptr when one exists.
  always_comb begin
    w_pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req[i]) w_pick = GW'(i);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req[i] && (GW'(i) >= r_rr_ptr)) w_pick = GW'(i);
    end
  end

  // Live inputs of the granted channel.
  always_comb begin
    w_g_ren   = 1'b0;
    w_g_wen   = 1'b0;
    w_g_addr  = '0;
    w_g_store = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant == GW'(i)) begin
        w_g_ren   = req_REN[i];
        w_g_wen   = req_WEN[i];
        w_g_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_g_store = req_store[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_to_cnt;

  assign w_timeout = (r_state == S_BUSY) && (r_to_cnt == CW'(TIMEOUT_CYC));

  // Held at zero while idle, so it always starts from zero on BUSY entry.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_to_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_to_cnt <= '0;
    end else if (ramstate != ACCESS && ramstate != ERROR && !w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    req_wait     = w_req;
    req_err      = '0;
    req_load     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        ramaddr  = w_g_addr;
        ramstore = w_g_store;
        if (!(w_g_ren || w_g_wen)) begin
          // Channel withdrew its request: abandon without touching the RAM.
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = w_grant_inc;
        end else begin
          ramWEN = w_g_wen;
          ramREN = w_g_ren & ~w_g_wen;
          if (ramstate == ACCESS) begin
            req_wait     = w_req & ~w_grant_oh;
            req_load     = ramload;
            w_state_nxt  = S_IDLE;
            w_rr_ptr_nxt = w_grant_inc;
          end else if (ramstate == ERROR || w_timeout) begin
            req_wait     = w_req & ~w_grant_oh;
            req_err      = w_grant_oh;
            w_state_nxt  = S_IDLE;
            w_rr_ptr_nxt = w_grant_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef RAM_ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic                     CLK = 1'b0;
  logic                     nRST;
  logic [NUM_CH-1:0]        req_REN, req_WEN;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_store;
  logic [NUM_CH-1:0]        req_wait, req_err;
  logic [DATA_W-1:0]        req_load;
  logic                     ramREN, ramWEN;
  logic [ADDR_W-1:0]        ramaddr;
  logic [DATA_W-1:0]        ramstore, ramload;
  ramstate_t                ramstate;

  int n_chk  = 0;
  int n_pass = 0;

  ram_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_REN(req_REN), .req_WEN(req_WEN),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load), .req_err(req_err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    req_REN   = '0;
    req_WEN   = '0;
    req_addr  = '0;
    req_store = '0;
    ramload   = '0;
    ramstate  = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    req_REN  = 2'b01;
    req_WEN  = 2'b10;
    ramstate = ACCESS;
    ramload  = 32'hCAFE_F00D;
    cyc();
    cyc();
    @(negedge CLK);
    n_chk++;
    if (req_wait !== 2'b11) $display("FAIL rst_wait got %b exp %b", req_wait, 2'b11);
    else n_pass++;
    n_chk++;
    if ({ramREN, ramWEN} !== 2'b00) $display("FAIL rst_ren_wen got %b exp %b", {ramREN, ramWEN}, 2'b00);
    else n_pass++;
    n_chk++;
    if (req_load !== 32'h0 || req_err !== 2'b00)
      $display("FAIL rst_load_err got %h/%b exp 0/00", req_load, req_err);
    else n_pass++;
    n_chk++;
    if (ramaddr !== 32'h0 || ramstore !== 32'h0)
      $display("FAIL rst_addr_store got %h/%h exp 0/0", ramaddr, ramstore);
    else n_pass++;
  endtask

  task automatic test_single_read();
    do_reset();
    req_REN = 2'b01;
    req_addr[0 +: ADDR_W] = 32'h100;
    @(negedge CLK);
    n_chk++;
    if (ramREN !== 1'b0 || req_wait !== 2'b01)
      $display("FAIL rd_c0 got ren=%b wait=%b exp ren=0 wait=01", ramREN, req_wait);
    else n_pass++;
    cyc();
    ramstate = ACCESS;
    ramload  = 32'hDEAD_BEEF;
    @(negedge CLK);
    n_chk++;
    if (req_load !== 32'hDEAD_BEEF) $display("FAIL rd_load got %h exp %h", req_load, 32'hDEAD_BEEF);
    else n_pass++;
    n_chk++;
    if (req_wait !== 2'b00) $display("FAIL rd_wait got %b exp %b", req_wait, 2'b00);
    else n_pass++;
    n_chk++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100)
      $display("FAIL rd_c1 got ren=%b wen=%b addr=%h exp ren=1 wen=0 addr=100", ramREN, ramWEN, ramaddr);
    else n_pass++;
    cyc();
    req_REN = 2'b00;
    @(negedge CLK);
    n_chk++;
    if (ramREN !== 1'b0 || req_load !== 32'h0)
      $display("FAIL rd_c2 got ren=%b load=%h exp ren=0 load=0", ramREN, req_load);
    else n_pass++;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_wait;
    logic [31:0] exp_addr;
    int          cnt0, cnt1, ch;
    cnt0 = 0;
    cnt1 = 0;
    do_reset();
    req_REN = 2'b11;
    req_addr[0 +: ADDR_W]      = 32'h0000_00A0;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_00B0;
    ramstate = ACCESS;
    ramload  = 32'h5555_AAAA;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (i % 2 == 0) begin
        n_chk++;
        if (ramREN !== 1'b0 || req_wait !== 2'b11 || req_load !== 32'h0)
          $display("FAIL rr_idle%0d got ren=%b wait=%b load=%h exp 0/11/0", i, ramREN, req_wait, req_load);
        else n_pass++;
      end else begin
        ch       = ((i - 1) / 2) % 2;
        exp_addr = (ch == 0) ? 32'h0000_00A0 : 32'h0000_00B0;
        exp_wait = (ch == 0) ? 2'b10 : 2'b01;
        n_chk++;
        if (ramREN !== 1'b1 || ramaddr !== exp_addr || req_wait !== exp_wait)
          $display("FAIL rr_grant%0d got ren=%b addr=%h wait=%b exp 1/%h/%b",
                   i, ramREN, ramaddr, req_wait, exp_addr, exp_wait);
        else n_pass++;
        if (ramREN === 1'b1 && ramaddr === 32'h0000_00A0) cnt0++;
        if (ramREN === 1'b1 && ramaddr === 32'h0000_00B0) cnt1++;
      end
      cyc();
    end
    n_chk++;
    if (cnt0 != 10 || cnt1 != 10) $display("FAIL rr_fair got %0d/%0d exp 10/10", cnt0, cnt1);
    else n_pass++;
    clear_inputs();
    cyc();
  endtask

  task automatic test_write_wins();
    do_reset();
    req_REN = 2'b10;
    req_WEN = 2'b10;
    req_addr[ADDR_W +: ADDR_W]  = 32'h0000_002C;
    req_store[0 +: DATA_W]      = 32'hFFFF_0000;
    req_store[DATA_W +: DATA_W] = 32'h1234_5678;
    @(negedge CLK);
    n_chk++;
    if (ramWEN !== 1'b0 || ramstore !== 32'h0)
      $display("FAIL wr_idle got wen=%b store=%h exp 0/0", ramWEN, ramstore);
    else n_pass++;
    cyc();
    @(negedge CLK);
    n_chk++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0)
      $display("FAIL wr_en got wen=%b ren=%b exp wen=1 ren=0", ramWEN, ramREN);
    else n_pass++;
    n_chk++;
    if (ramstore !== 32'h1234_5678 || ramaddr !== 32'h0000_002C)
      $display("FAIL wr_data got store=%h addr=%h exp 12345678/0000002c", ramstore, ramaddr);
    else n_pass++;
    cyc();
    ramstate = ACCESS;
    @(negedge CLK);
    n_chk++;
    if (req_wait !== 2'b00 || req_err !== 2'b00)
      $display("FAIL wr_done got wait=%b err=%b exp 00/00", req_wait, req_err);
    else n_pass++;
    cyc();
    clear_inputs();
    cyc();
  endtask

  task automatic test_error();
    do_reset();
    req_REN = 2'b10;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_0044;
    ramstate = ERROR;
    @(negedge CLK);
    n_chk++;
    if (req_err !== 2'b00 || req_wait !== 2'b10)
      $display("FAIL err_idle_ignore got err=%b wait=%b exp 00/10", req_err, req_wait);
    else n_pass++;
    cyc();
    ramstate = BUSY;
    @(negedge CLK);
    n_chk++;
    if (req_err !== 2'b00 || ramREN !== 1'b1 || req_wait !== 2'b10)
      $display("FAIL err_busy got err=%b ren=%b wait=%b exp 00/1/10", req_err, ramREN, req_wait);
    else n_pass++;
    cyc();
    ramstate = ERROR;
    @(negedge CLK);
    n_chk++;
    if (req_err !== 2'b10) $display("FAIL err_pulse got %b exp %b", req_err, 2'b10);
    else n_pass++;
    n_chk++;
    if (req_wait !== 2'b00) $display("FAIL err_wait got %b exp %b", req_wait, 2'b00);
    else n_pass++;
    cyc();
    ramstate = FREE;
    @(negedge CLK);
    n_chk++;
    if (req_err !== 2'b00 || ramREN !== 1'b0 || req_wait !== 2'b10)
      $display("FAIL err_after got err=%b ren=%b wait=%b exp 00/0/10", req_err, ramREN, req_wait);
    else n_pass++;
    clear_inputs();
    cyc();
    cyc();
  endtask

  task automatic test_abort();
    do_reset();
    req_REN = 2'b01;
    req_addr[0 +: ADDR_W]      = 32'h0000_0010;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_0020;
    ramstate = BUSY;
    cyc();
    req_REN = 2'b00;
    @(negedge CLK);
    n_chk++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || req_wait !== 2'b00)
      $display("FAIL abort_cyc got ren=%b wen=%b wait=%b exp 0/0/00", ramREN, ramWEN, req_wait);
    else n_pass++;
    cyc();
    req_REN = 2'b11;
    cyc();
    @(negedge CLK);
    n_chk++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h0000_0020)
      $display("FAIL abort_rr got ren=%b addr=%h exp 1/00000020", ramREN, ramaddr);
    else n_pass++;
    clear_inputs();
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    logic ok;
    do_reset();
    req_REN = 2'b01;
    req_addr[0 +: ADDR_W] = 32'h0000_0300;
    ramstate = BUSY;
    cyc();
`ifdef RAM_ARB_TIMEOUT_EN
    for (int b = 1; b <= 4; b++) begin
      @(negedge CLK);
      n_chk++;
      if (req_err !== 2'b00 || req_wait !== 2'b01)
        $display("FAIL to_wait%0d got err=%b wait=%b exp 00/01", b, req_err, req_wait);
      else n_pass++;
      cyc();
    end
    @(negedge CLK);
    n_chk++;
    if (req_err !== 2'b01 || req_wait !== 2'b00)
      $display("FAIL to_pulse got err=%b wait=%b exp 01/00", req_err, req_wait);
    else n_pass++;
    cyc();
    @(negedge CLK);
    n_chk++;
    if (req_err !== 2'b00 || ramREN !== 1'b0)
      $display("FAIL to_idle got err=%b ren=%b exp 00/0", req_err, ramREN);
    else n_pass++;
`else
    ok = 1'b1;
    for (int b = 0; b < 100; b++) begin
      @(negedge CLK);
      if (req_wait !== 2'b01 || req_err !== 2'b00 || ramREN !== 1'b1) ok = 1'b0;
      cyc();
    end
    n_chk++;
    if (ok !== 1'b1) $display("FAIL no_timeout got ok=%b exp 1", ok);
    else n_pass++;
`endif
    clear_inputs();
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req_REN = 2'b01;
    req_addr[0 +: ADDR_W] = 32'h0000_0400;
    ramstate = BUSY;
    cyc();
    @(negedge CLK);
    n_chk++;
    if (ramREN !== 1'b1) $display("FAIL rmb_busy got ren=%b exp 1", ramREN);
    else n_pass++;
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST     = 1'b1;
    ramstate = ERROR;
    @(negedge CLK);
    n_chk++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0)
      $display("FAIL rmb_ram got ren=%b wen=%b exp 0/0", ramREN, ramWEN);
    else n_pass++;
    n_chk++;
    if (req_err !== 2'b00 || req_wait !== 2'b01)
      $display("FAIL rmb_err got err=%b wait=%b exp 00/01", req_err, req_wait);
    else n_pass++;
    clear_inputs();
    cyc();
    cyc();
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_wins();
    test_error();
    test_abort();
    test_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL take parameters, one per line as name, default, meaning:
- NUM_CH, 2, requesting channels (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only under RAM_ARB_TIMEOUT_EN)

REQ-002 The block SHALL have ports, one per line as name, direction, width, meaning:
- CLK  in  1  single clock, rising edge
- nRST  in  1  synchronous active-low reset
- req_REN  in  NUM_CH  per-channel read request
- req_WEN  in  NUM_CH  per-channel write request
- req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W]
- req_store  in  NUM_CH*DATA_W  packed write data
- req_wait  out  NUM_CH  per-channel stall
- req_load  out  DATA_W  read data, broadcast to all channels
- req_err  out  NUM_CH  one-cycle error pulse
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  ramstate_t  RAM status (FREE, BUSY, ACCESS, ERROR)

REQ-003 Clock and reset SHALL be the single clock CLK and the synchronous active-low reset nRST; no other clock or reset exists.

Function
REQ-004 The FSM SHALL have two states, IDLE and BUSY, plus registers grant (clog2(NUM_CH) bits) and rr_ptr.
REQ-005 A channel SHALL be requesting when its req_REN or req_WEN bit is 1.
REQ-006 In IDLE with at least one channel requesting, the block SHALL register grant as the first requesting channel at or after rr_ptr, wrapping modulo NUM_CH, and go to BUSY next cycle.
REQ-007 In IDLE the block SHALL hold ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0, and SHALL ignore ramstate.
REQ-008 In BUSY the block SHALL combinationally drive ramaddr and ramstore from the granted channel's live inputs.
REQ-009 In BUSY, if the granted channel's req_WEN=1, the block SHALL set ramWEN=1 and ramREN=0 (write wins when both are set); otherwise it SHALL set ramREN=req_REN.
REQ-010 A channel SHALL hold its address, data and request stable until its req_wait drops.
REQ-011 Completion: in BUSY with ramstate==ACCESS, the block SHALL drive req_wait[grant]=0 and req_load=ramload in that same cycle, then go to IDLE with rr_ptr=(grant+1) mod NUM_CH.
REQ-012 On ramstate==ERROR in BUSY, the block SHALL drive req_wait[grant]=0 and req_err[grant]=1 for that cycle, then go to IDLE with rr_ptr advanced as in REQ-011.
REQ-013 If the granted channel drops both REN and WEN while in BUSY (abort), the block SHALL drive ramREN=ramWEN=0 that cycle, go to IDLE, and advance rr_ptr.
REQ-014 req_wait[i] SHALL equal (req_REN[i] | req_WEN[i]) except during the completion, error or timeout cycle of the granted channel.
REQ-015 req_load SHALL be 0 outside completion cycles.
REQ-016 Minimum latency SHALL be 2 cycles: request in cycle 0, grant in cycle 1, earliest completion in cycle 1.
REQ-017 Back-to-back accesses SHALL insert one IDLE cycle between grants.

Reset
REQ-018 While nRST=0 at a rising edge, the block SHALL set state=IDLE, grant=0, rr_ptr=0 and the timeout counter to 0.
REQ-019 Outputs SHALL then follow IDLE rules: ram* outputs 0, req_err 0, req_load 0, req_wait equal to the request bits.
REQ-020 A reset asserted during BUSY SHALL abandon the access with no req_err pulse.

Configuration
REQ-021 With RAM_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle without ACCESS or ERROR.
REQ-022 Under RAM_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC the block SHALL behave as in REQ-012: req_err pulse, req_wait drop, return to IDLE.
REQ-023 Without RAM_ARB_TIMEOUT_EN, the block SHALL have no counter and SHALL wait in BUSY indefinitely.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- NUM_CH=2; ch0 read addr 0x100, ramstate ACCESS on cycle 1 with ramload 0xDEADBEEF -> req_load=0xDEADBEEF and req_wait[0]=0 in cycle 1, ramREN=1 in cycle 1 only.
- ch0 and ch1 request continuously -> grants alternate 0,1,0,1 with one IDLE cycle between grants; no starvation over 20 accesses.
- ch1 sets REN=WEN=1 with store 0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
- ramstate=ERROR during ch1 BUSY -> req_err=2'b10 for one cycle, req_wait[1]=0, next state IDLE.
- RAM_ARB_TIMEOUT_EN, TIMEOUT_CYC=4, ramstate held BUSY -> req_err pulse after 4 BUSY cycles; without the macro, req_wait stays 1 for 100 cycles.
- nRST=0 asserted mid-BUSY -> next cycle IDLE, ramREN=ramWEN=0, no req_err.
